fft_reorder_buf: RTL

- Downstream neighbour of the radix-2 SDF FFT core.
- Consumes the core's bit-reversed-order complex output stream and re-emits each 2^N-point frame in natural frequency order.
- Ping-pong buffer (two banks of 2^N complex words) so one frame is written while the previous one drains.
- Output side uses a valid/ready handshake so later spectral stages can apply backpressure.

---
 rtl/fft_reorder_buf.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: takes bit-reversed FFT output frames and emits
// each 2^N-point frame in natural order over a valid/ready stream.
module fft_reorder_buf #(
   parameter int N = 3,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_start,
   input  logic         in_valid,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         out_first,
   output logic         out_last,
   output logic         ovf,
   output logic         frame_err
);

   localparam int             DEPTH    = 1 << N;
   localparam logic [N-1:0]   IDX_ZERO = '0;
   localparam logic [N-1:0]   IDX_LAST = N'(DEPTH - 1);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
   typedef enum logic       {R_IDLE, R_DRAIN}         rstate_t;

   function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
      logic [N-1:0] b;
      for (int i = 0; i < N; i++) b[i] = a[N-1-i];
      return b;
   endfunction

   // Address is {bank, index}; the two banks share one array.
   logic [2*W-1:0] r_mem [0:2*DEPTH-1];

   wstate_t      r_wstate, w_wstate;
   rstate_t      r_rstate, w_rstate;
   logic [1:0]   r_full, w_full;
   logic         r_wbank, w_wbank;
   logic         r_rbank, w_rbank;
   logic [N-1:0] r_wcnt, w_wcnt;
   logic [N-1:0] r_rcnt, w_rcnt;
   logic [W-1:0] r_out_re, r_out_im;
   logic         r_out_valid, w_out_valid;
   logic         r_out_first, w_out_first;
   logic         r_out_last, w_out_last;
   logic         r_ovf, w_ovf;
   logic         r_frame_err, w_frame_err;

   logic         w_we, w_set_full, w_clr_full, w_load;
   logic [N:0]   w_waddr, w_raddr;
   logic [2*W-1:0] w_rdata;
   logic         w_rd_done, w_wbank_free, w_other;

   // A bank whose last word is handed off this edge may be refilled this edge.
   assign w_rd_done    = (r_rstate == R_DRAIN) && r_out_valid && out_ready && r_out_last;
   assign w_wbank_free = !r_full[r_wbank] || (w_rd_done && (r_rbank == r_wbank));
   assign w_other      = ~r_rbank;
   assign w_rdata      = r_mem[w_raddr];

   // Write side: scatter incoming samples to their natural-order slots.
   always_comb begin
      w_wstate    = r_wstate;
      w_wcnt      = r_wcnt;
      w_wbank     = r_wbank;
      w_we        = 1'b0;
      w_waddr     = {r_wbank, bitrev(r_wcnt)};
      w_set_full  = 1'b0;
      w_ovf       = r_ovf;
      w_frame_err = r_frame_err;
      case (r_wstate)
         W_FILL: begin
            if (in_valid) begin
               w_we = 1'b1;
               if (in_start) begin
                  w_frame_err = 1'b1;
                  w_waddr     = {r_wbank, IDX_ZERO};
                  w_wcnt      = N'(1);
               end else if (r_wcnt == IDX_LAST) begin
                  w_set_full = 1'b1;
                  w_wbank    = ~r_wbank;
                  w_wcnt     = IDX_ZERO;
                  w_wstate   = W_IDLE;
               end else begin
                  w_wcnt = r_wcnt + N'(1);
               end
            end
         end
         default: begin
            if (in_valid && in_start) begin
               if (w_wbank_free) begin
                  w_we     = 1'b1;
                  w_waddr  = {r_wbank, IDX_ZERO};
                  w_wcnt   = N'(1);
                  w_wstate = W_FILL;
               end else begin
                  w_ovf    = 1'b1;
                  w_wstate = W_DROP;
               end
            end
         end
      endcase
   end

   // Read side: walk a full bank linearly, chaining into the other bank.
   always_comb begin
      w_rstate    = r_rstate;
      w_rbank     = r_rbank;
      w_rcnt      = r_rcnt;
      w_out_valid = r_out_valid;
      w_out_first = r_out_first;
      w_out_last  = r_out_last;
      w_load      = 1'b0;
      w_raddr     = {r_rbank, r_rcnt};
      w_clr_full  = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            if (r_full[r_rbank]) begin
               w_load      = 1'b1;
               w_raddr     = {r_rbank, IDX_ZERO};
               w_rcnt      = IDX_ZERO;
               w_out_valid = 1'b1;
               w_out_first = 1'b1;
               w_out_last  = 1'b0;
               w_rstate    = R_DRAIN;
            end
         end
         R_DRAIN: begin
            if (r_out_valid && out_ready) begin
               if (r_out_last) begin
                  w_clr_full = 1'b1;
                  w_rbank    = w_other;
                  w_out_last = 1'b0;
                  if (r_full[w_other]) begin
                     w_load      = 1'b1;
                     w_raddr     = {w_other, IDX_ZERO};
                     w_rcnt      = IDX_ZERO;
                     w_out_first = 1'b1;
                  end else begin
                     w_out_valid = 1'b0;
                     w_out_first = 1'b0;
                     w_rstate    = R_IDLE;
                  end
               end else begin
                  w_rcnt      = r_rcnt + N'(1);
                  w_load      = 1'b1;
                  w_raddr     = {r_rbank, w_rcnt};
                  w_out_first = 1'b0;
                  w_out_last  = (w_rcnt == IDX_LAST);
               end
            end
         end
         default: ;
      endcase
   end

   // Clear before set: the set targets the write bank, which is never the
   // bank being retired on the same edge.
   always_comb begin
      w_full = r_full;
      if (w_clr_full) w_full[r_rbank] = 1'b0;
      if (w_set_full) w_full[r_wbank] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wstate    <= W_IDLE;
         r_rstate    <= R_IDLE;
         r_full      <= 2'b00;
         r_wbank     <= 1'b0;
         r_rbank     <= 1'b0;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_out_re    <= '0;
         r_out_im    <= '0;
         r_out_valid <= 1'b0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_ovf       <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_wstate    <= w_wstate;
         r_rstate    <= w_rstate;
         r_full      <= w_full;
         r_wbank     <= w_wbank;
         r_rbank     <= w_rbank;
         r_wcnt      <= w_wcnt;
         r_rcnt      <= w_rcnt;
         r_out_valid <= w_out_valid;
         r_out_first <= w_out_first;
         r_out_last  <= w_out_last;
         r_ovf       <= w_ovf;
         r_frame_err <= w_frame_err;
         if (w_load) begin
            r_out_re <= w_rdata[2*W-1:W];
            r_out_im <= w_rdata[W-1:0];
         end
      end
   end

   // NOTE: storage has no reset; the full flags alone decide what is valid.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= {in_re, in_im};
   end

   assign out_valid = r_out_valid;
   assign out_re    = r_out_re;
   assign out_im    = r_out_im;
   assign out_first = r_out_first;
   assign out_last  = r_out_last;
   assign ovf       = r_ovf;
   assign frame_err = r_frame_err;

endmodule
